// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU stage and its command issuer.
package alu_pkg;

    // Arithmetic command set (mode = 1)
    typedef enum logic [3:0] {
        ARITH_ADD     = 4'd0,
        ARITH_SUB     = 4'd1,
        ARITH_ADD_CIN = 4'd2,
        ARITH_SUB_CIN = 4'd3,
        ARITH_INC_A   = 4'd4,
        ARITH_DEC_A   = 4'd5,
        ARITH_INC_B   = 4'd6,
        ARITH_DEC_B   = 4'd7,
        ARITH_CMP     = 4'd8,
        ARITH_INC_MUL = 4'd9,
        ARITH_SHL_MUL = 4'd10
    } arith_cmd_e;

    // Logic command set (mode = 0)
    typedef enum logic [3:0] {
        LOGIC_AND     = 4'd0,
        LOGIC_NAND    = 4'd1,
        LOGIC_OR      = 4'd2,
        LOGIC_NOR     = 4'd3,
        LOGIC_XOR     = 4'd4,
        LOGIC_XNOR    = 4'd5,
        LOGIC_NOT_A   = 4'd6,
        LOGIC_NOT_B   = 4'd7,
        LOGIC_SHR1_A  = 4'd8,
        LOGIC_SHL1_A  = 4'd9,
        LOGIC_SHR1_B  = 4'd10,
        LOGIC_SHL1_B  = 4'd11,
        LOGIC_ROL_A_B = 4'd12,
        LOGIC_ROR_A_B = 4'd13
    } logic_cmd_e;

    // Which operands the ALU should treat as valid
    typedef enum logic [1:0] {
        INV_INP           = 2'b00,
        OPA_VALID         = 2'b01,
        OPB_VALID         = 2'b10,
        OPA_AND_OPB_VALID = 2'b11
    } inp_valid_e;

    // Request word layout: {tag, mode, cmd, inp_valid, cin, opa, opb}
    localparam int REQ_BASE_W = 24;
    localparam int OPB_LSB    = 0;
    localparam int OPA_LSB    = 8;
    localparam int CIN_BIT    = 16;
    localparam int INPV_LSB   = 17;
    localparam int CMD_LSB    = 19;
    localparam int MODE_BIT   = 23;
    localparam int TAG_LSB    = 24;

    // Flag vector bit positions: {err, ov, cout, g, l, e}
    localparam int FLAG_W    = 6;
    localparam int FLAG_ERR  = 5;
    localparam int FLAG_OV   = 4;
    localparam int FLAG_COUT = 3;
    localparam int FLAG_G    = 2;
    localparam int FLAG_L    = 1;
    localparam int FLAG_E    = 0;

    // Total request word width for a given tag width
    function automatic int req_word_w(input int tag_w);
        return tag_w + REQ_BASE_W;
    endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Synchronous request FIFO; the head entry is visible on dout without a read delay.
module alu_req_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 28
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array, written at the tail; contents need no reset since level gates them
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; level tracks occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                level <= level + LW'(1);
            end else if (do_pop && !do_push) begin
                level <= level - LW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues buffered ALU requests one per cycle and returns tagged results with backpressure.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [TAG_W-1:0]         req_tag,
    input  logic                     req_mode,
    input  logic [3:0]               req_cmd,
    input  logic [1:0]               req_inp_valid,
    input  logic                     req_cin,
    input  logic [7:0]               req_opa,
    input  logic [7:0]               req_opb,
    output logic                     alu_ce,
    output logic                     alu_mode,
    output logic                     alu_cin,
    output logic [3:0]               alu_cmd,
    output logic [1:0]               alu_inp_valid,
    output logic [7:0]               alu_opa,
    output logic [7:0]               alu_opb,
    input  logic [15:0]              alu_res,
    input  logic                     alu_err,
    input  logic                     alu_ov,
    input  logic                     alu_cout,
    input  logic                     alu_g,
    input  logic                     alu_l,
    input  logic                     alu_e,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [TAG_W-1:0]         rsp_tag,
    output logic [15:0]              rsp_res,
    output logic [5:0]               rsp_flags,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [15:0]              err_cnt
);

    localparam int REQ_W = req_word_w(TAG_W);

    logic [REQ_W-1:0] req_word;
    logic [REQ_W-1:0] head_word;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             stall;
    logic [TAG_W-1:0] issue_tag;

    logic             s1_v;
    logic [TAG_W-1:0] s1_tag;
    logic             s2_v;
    logic [TAG_W-1:0] s2_tag;

    assign req_word = {req_tag, req_mode, req_cmd, req_inp_valid, req_cin, req_opa, req_opb};

    assign req_ready = !fifo_full;
    assign push      = req_valid && req_ready;
    assign stall     = s2_v && !rsp_ready;
    assign alu_ce    = !stall;
    assign pop       = alu_ce && !fifo_empty;

    alu_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (req_word),
        .dout  (head_word),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Drive ALU pins from the FIFO head, or an all-zero invalid bubble when nothing is queued
    always_comb begin
        alu_mode      = 1'b0;
        alu_cin       = 1'b0;
        alu_cmd       = 4'd0;
        alu_inp_valid = INV_INP;
        alu_opa       = 8'd0;
        alu_opb       = 8'd0;
        issue_tag     = '0;
        if (!fifo_empty) begin
            alu_mode      = head_word[MODE_BIT];
            alu_cin       = head_word[CIN_BIT];
            alu_cmd       = head_word[CMD_LSB +: 4];
            alu_inp_valid = head_word[INPV_LSB +: 2];
            alu_opa       = head_word[OPA_LSB +: 8];
            alu_opb       = head_word[OPB_LSB +: 8];
            issue_tag     = head_word[TAG_LSB +: TAG_W];
        end
    end

    // Valid/tag shadow of the ALU's input and output registers, frozen together with the ALU
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v   <= 1'b0;
            s1_tag <= '0;
            s2_v   <= 1'b0;
            s2_tag <= '0;
        end else if (alu_ce) begin
            s1_v   <= pop;
            s1_tag <= issue_tag;
            s2_v   <= s1_v;
            s2_tag <= s1_tag;
        end
    end

    assign rsp_valid = s2_v;
    assign rsp_tag   = s2_tag;
    assign rsp_res   = alu_res;
    assign rsp_flags = {alu_err, alu_ov, alu_cout, alu_g, alu_l, alu_e};

    // Saturating count of delivered responses that carried an ALU error
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= 16'd0;
        end else if (rsp_valid && rsp_ready && alu_err && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural two-stage ALU and a response scoreboard.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [TAG_W-1:0] req_tag;
    logic             req_mode;
    logic [3:0]       req_cmd;
    logic [1:0]       req_inp_valid;
    logic             req_cin;
    logic [7:0]       req_opa;
    logic [7:0]       req_opb;
    logic             alu_ce;
    logic             alu_mode;
    logic             alu_cin;
    logic [3:0]       alu_cmd;
    logic [1:0]       alu_inp_valid;
    logic [7:0]       alu_opa;
    logic [7:0]       alu_opb;
    logic [15:0]      alu_res;
    logic             alu_err;
    logic             alu_ov;
    logic             alu_cout;
    logic             alu_g;
    logic             alu_l;
    logic             alu_e;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [TAG_W-1:0] rsp_tag;
    logic [15:0]      rsp_res;
    logic [5:0]       rsp_flags;
    logic [LVL_W-1:0] fifo_level;
    logic [15:0]      err_cnt;

    alu_issue_ctrl #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_tag       (req_tag),
        .req_mode      (req_mode),
        .req_cmd       (req_cmd),
        .req_inp_valid (req_inp_valid),
        .req_cin       (req_cin),
        .req_opa       (req_opa),
        .req_opb       (req_opb),
        .alu_ce        (alu_ce),
        .alu_mode      (alu_mode),
        .alu_cin       (alu_cin),
        .alu_cmd       (alu_cmd),
        .alu_inp_valid (alu_inp_valid),
        .alu_opa       (alu_opa),
        .alu_opb       (alu_opb),
        .alu_res       (alu_res),
        .alu_err       (alu_err),
        .alu_ov        (alu_ov),
        .alu_cout      (alu_cout),
        .alu_g         (alu_g),
        .alu_l         (alu_l),
        .alu_e         (alu_e),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_tag       (rsp_tag),
        .rsp_res       (rsp_res),
        .rsp_flags     (rsp_flags),
        .fifo_level    (fifo_level),
        .err_cnt       (err_cnt)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU result for the subset of commands exercised here: {flags, res}
    function automatic logic [21:0] aluCompute(input logic mode, input logic [3:0] cmd,
                                               input logic [1:0] inpv, input logic [7:0] a,
                                               input logic [7:0] b);
        logic [15:0] r;
        logic [5:0]  f;
        logic [8:0]  sum;
        logic [15:0] dbl;
        r = 16'd0;
        f = 6'd0;
        if (inpv == INV_INP) begin
            f[FLAG_ERR] = 1'b1;
        end else if (mode) begin
            case (cmd)
                ARITH_ADD: begin
                    sum = {1'b0, a} + {1'b0, b};
                    r = {7'd0, sum};
                    f[FLAG_COUT] = sum[8];
                end
                ARITH_INC_MUL: r = (16'(a) + 16'd1) * (16'(b) + 16'd1);
                ARITH_INC_A:   r = 16'(a) + 16'd1;
                default:       f[FLAG_ERR] = 1'b1;
            endcase
        end else begin
            case (cmd)
                LOGIC_ROL_A_B: begin
                    dbl = {a, a} << b[2:0];
                    r = {8'd0, dbl[15:8]};
                    if (b[7:4] != 4'd0) f[FLAG_ERR] = 1'b1;
                end
                default: f[FLAG_ERR] = 1'b1;
            endcase
        end
        return {f, r};
    endfunction

    logic        m1Mode;
    logic [3:0]  m1Cmd;
    logic [1:0]  m1Inpv;
    logic [7:0]  m1Opa;
    logic [7:0]  m1Opb;
    logic [21:0] m2Out;

    // Two-register ALU model: input capture then registered result, both frozen when ce is low
    always_ff @(posedge clk) begin
        if (rst) begin
            m1Mode <= 1'b0;
            m1Cmd  <= 4'd0;
            m1Inpv <= 2'd0;
            m1Opa  <= 8'd0;
            m1Opb  <= 8'd0;
            m2Out  <= 22'd0;
        end else if (alu_ce) begin
            m1Mode <= alu_mode;
            m1Cmd  <= alu_cmd;
            m1Inpv <= alu_inp_valid;
            m1Opa  <= alu_opa;
            m1Opb  <= alu_opb;
            m2Out  <= aluCompute(m1Mode, m1Cmd, m1Inpv, m1Opa, m1Opb);
        end
    end

    assign alu_res  = m2Out[15:0];
    assign alu_err  = m2Out[16 + FLAG_ERR];
    assign alu_ov   = m2Out[16 + FLAG_OV];
    assign alu_cout = m2Out[16 + FLAG_COUT];
    assign alu_g    = m2Out[16 + FLAG_G];
    assign alu_l    = m2Out[16 + FLAG_L];
    assign alu_e    = m2Out[16 + FLAG_E];

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [15:0]      res;
        logic [15:0]      resMask;
        logic [5:0]       flags;
        logic [5:0]       flagMask;
    } exp_t;

    exp_t        sb[$];
    exp_t        pending;
    bit          accepted;
    int          passCnt;
    int          totalCnt;
    int          cycleCnt;
    int          lastRsp;
    int          prevRsp;
    logic [15:0] expErrCnt;

    // Single comparison point: counts, passes or reports
    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
    endtask

    // Compare a delivered response against the oldest scoreboard entry
    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            check("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
            e = sb.pop_front();
            check("rsp_tag", 32'(rsp_tag), 32'(e.tag));
            check("rsp_res", 32'(rsp_res & e.resMask), 32'(e.res & e.resMask));
            check("rsp_flags", 32'(rsp_flags & e.flagMask), 32'(e.flags & e.flagMask));
            if (e.flags[FLAG_ERR] && (expErrCnt != 16'hFFFF)) expErrCnt++;
            prevRsp = lastRsp;
            lastRsp = cycleCnt;
        end
    endtask

    // One clock: checks just before the edge, records handshakes, returns on the next falling edge
    task automatic cycle();
        #4;
        cycleCnt++;
        check("err_cnt", 32'(err_cnt), 32'(expErrCnt));
        if (sb.size() == 0) begin
            check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        end else if (rsp_valid && !rsp_ready) begin
            check("stall_ce", 32'(alu_ce), 32'd0);
            check("stall_tag", 32'(rsp_tag), 32'(sb[0].tag));
            check("stall_res", 32'(rsp_res & sb[0].resMask), 32'(sb[0].res & sb[0].resMask));
        end
        if (rsp_valid && rsp_ready) checkOutput();
        if (req_valid && req_ready) begin
            sb.push_back(pending);
            accepted = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present one request and hold it until accepted (bounded), recording its expected result
    task automatic applyStimulus(input logic [TAG_W-1:0] tag, input logic mode,
                                 input logic [3:0] cmd, input logic [1:0] inpv,
                                 input logic [7:0] opa, input logic [7:0] opb,
                                 input logic [15:0] expRes, input logic [15:0] resMask,
                                 input logic [5:0] expFlags, input logic [5:0] flagMask);
        req_tag       = tag;
        req_mode      = mode;
        req_cmd       = cmd;
        req_inp_valid = inpv;
        req_cin       = 1'b0;
        req_opa       = opa;
        req_opb       = opb;
        req_valid     = 1'b1;
        pending.tag      = tag;
        pending.res      = expRes;
        pending.resMask  = resMask;
        pending.flags    = expFlags;
        pending.flagMask = flagMask;
        accepted = 1'b0;
        for (int i = 0; i < 30 && !accepted; i++) cycle();
        check("req_accept", 32'(accepted), 32'd1);
        req_valid = 1'b0;
    endtask

    // Run until every expected response has been delivered, within a cycle budget
    task automatic drain(input int maxCycles);
        for (int i = 0; i < maxCycles && sb.size() != 0; i++) cycle();
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    // Hard stop in case something escapes the bounded loops
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    localparam logic [5:0] M_ERR      = 6'b100000;
    localparam logic [5:0] M_ERR_COUT = 6'b101000;

    initial begin
        passCnt       = 0;
        totalCnt      = 0;
        cycleCnt      = 0;
        lastRsp       = 0;
        prevRsp       = 0;
        expErrCnt     = 16'd0;
        rst           = 1'b1;
        req_valid     = 1'b0;
        req_tag       = '0;
        req_mode      = 1'b0;
        req_cmd       = 4'd0;
        req_inp_valid = 2'd0;
        req_cin       = 1'b0;
        req_opa       = 8'd0;
        req_opb       = 8'd0;
        rsp_ready     = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] reset state");
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_alu_ce", 32'(alu_ce), 32'd1);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);

        $display("[TB] ADD with carry and two-cycle latency");
        applyStimulus(4'd3, 1'b1, ARITH_ADD, OPA_AND_OPB_VALID, 8'hFF, 8'h01,
                      16'h0100, 16'hFFFF, 6'b001000, M_ERR_COUT);
        check("add_lat0", 32'(rsp_valid), 32'd0);
        cycle();
        check("add_lat1", 32'(rsp_valid), 32'd0);
        cycle();
        drain(10);
        check("add_rsp_cycle", 32'(lastRsp), 32'(cycleCnt));

        $display("[TB] back-to-back MULT_INC and INC_A");
        applyStimulus(4'd4, 1'b1, ARITH_INC_MUL, OPA_AND_OPB_VALID, 8'd3, 8'd4,
                      16'h0014, 16'hFFFF, 6'b000000, M_ERR);
        applyStimulus(4'd5, 1'b1, ARITH_INC_A, OPA_VALID, 8'h7F, 8'h00,
                      16'h0080, 16'hFFFF, 6'b000000, M_ERR);
        drain(10);
        check("b2b_consecutive", 32'(lastRsp - prevRsp), 32'd1);

        $display("[TB] invalid operands");
        applyStimulus(4'd6, 1'b0, LOGIC_AND, INV_INP, 8'h55, 8'hAA,
                      16'h0000, 16'hFFFF, 6'b100000, M_ERR);
        drain(10);
        check("inv_err_cnt", 32'(err_cnt), 32'd1);
        repeat (4) cycle();

        $display("[TB] backpressure with six queued ops");
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(4'(i), 1'b1, ARITH_ADD, OPA_AND_OPB_VALID, 8'(i * 16 + 1), 8'd2,
                          16'(i * 16 + 3), 16'hFFFF, 6'b000000, M_ERR_COUT);
        end
        check("bp_alu_ce", 32'(alu_ce), 32'd0);
        check("bp_level", 32'(fifo_level), 32'd4);
        check("bp_req_ready", 32'(req_ready), 32'd0);
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        repeat (3) cycle();
        rsp_ready = 1'b1;
        drain(20);
        check("bp_level_drained", 32'(fifo_level), 32'd0);

        $display("[TB] rotate-left error and result");
        applyStimulus(4'd7, 1'b0, LOGIC_ROL_A_B, OPA_AND_OPB_VALID, 8'h81, 8'h10,
                      16'h0000, 16'h0000, 6'b100000, M_ERR);
        applyStimulus(4'd8, 1'b0, LOGIC_ROL_A_B, OPA_AND_OPB_VALID, 8'h81, 8'h02,
                      16'h0006, 16'hFFFF, 6'b000000, M_ERR);
        drain(10);
        check("rol_err_cnt", 32'(err_cnt), 32'd2);

        $display("[TB] reset with ops in flight");
        rsp_ready = 1'b0;
        applyStimulus(4'd10, 1'b1, ARITH_ADD, OPA_AND_OPB_VALID, 8'h10, 8'h01,
                      16'h0011, 16'hFFFF, 6'b000000, M_ERR);
        applyStimulus(4'd11, 1'b1, ARITH_ADD, OPA_AND_OPB_VALID, 8'h20, 8'h01,
                      16'h0021, 16'hFFFF, 6'b000000, M_ERR);
        applyStimulus(4'd12, 1'b1, ARITH_ADD, OPA_AND_OPB_VALID, 8'h30, 8'h01,
                      16'h0031, 16'hFFFF, 6'b000000, M_ERR);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        sb.delete();
        expErrCnt = 16'd0;
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_level", 32'(fifo_level), 32'd0);
        check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd1);
        rsp_ready = 1'b1;
        repeat (3) cycle();
        applyStimulus(4'd9, 1'b1, ARITH_ADD, OPA_AND_OPB_VALID, 8'h12, 8'h34,
                      16'h0046, 16'hFFFF, 6'b000000, M_ERR_COUT);
        drain(10);
        repeat (3) cycle();

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
